// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with BCD decode, blanking,
// guard time between digit slots and a tear-free double buffer updated only at frame boundaries.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  load_ack,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    typedef struct packed {
        logic [N_DIGITS-1:0][3:0] bcd;
        logic [N_DIGITS-1:0]      blank;
        logic [N_DIGITS-1:0]      dp;
    } frame_t;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    frame_t              active_q, active_d;
    frame_t              pending_q, pending_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                tick;
    logic                frame_end;
    logic                cur_blank;

    function automatic logic [6:0] decode(input logic [3:0] digit);
        case (digit)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        frame_end = tick && (idx_q == IDX_LAST);

        presc_d   = tick ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        active_d  = active_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        ack_d     = frame_end && busy_q;
        // Transfer uses the old pending value, so a coincident load lands in the next frame.
        if (ack_d) begin
            active_d = pending_q;
            busy_d   = 1'b0;
        end
        if (load) begin
            pending_d = {bcd_in, blank_in, dp_in};
            busy_d    = 1'b1;
        end

        cur_blank = active_q.blank[idx_q];
        seg_d     = cur_blank ? 7'h7F : decode(active_q.bcd[idx_q]);
        dp_d      = cur_blank | ~active_q.dp[idx_q];
        an_d      = '1;
        if (!cur_blank && (presc_q >= GUARD_END)) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            idx_q          <= '0;
            // NOTE: the buffers are plain flops, so they take a reset value; all-blank keeps the display dark.
            active_q.bcd   <= '0;
            active_q.blank <= '1;
            active_q.dp    <= '0;
            pending_q      <= '0;
            busy_q         <= 1'b0;
            ack_q          <= 1'b0;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            an_q           <= '1;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign busy     = busy_q;
    assign load_ack = ack_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs on each rising edge,
// and a monitor on the falling edge pops and compares them against the registered DUT outputs.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int G     = 1;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        busy;
    logic        load_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd_in   (bcd_in),
        .blank_in (blank_in),
        .dp_in    (dp_in),
        .load     (load),
        .busy     (busy),
        .load_ack (load_ack),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       busy;
        logic       ack;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Reference model state: n counts cycles since reset release; slot/position follow arithmetically.
    int          n = 0;
    logic [15:0] m_act_bcd,  m_pend_bcd;
    logic [3:0]  m_act_blank, m_pend_blank;
    logic [3:0]  m_act_dp,    m_pend_dp;
    logic        m_busy;

    always @(posedge clk) begin : model
        obs_t e;
        int   pos;
        int   slot;
        bit   boundary;
        bit   dark;
        if (reset) begin
            n            = 0;
            m_act_bcd    = 16'h0;
            m_act_blank  = 4'hF;
            m_act_dp     = 4'h0;
            m_pend_bcd   = 16'h0;
            m_pend_blank = 4'h0;
            m_pend_dp    = 4'h0;
            m_busy       = 1'b0;
            e.seg  = 7'h7F;
            e.dp   = 1'b1;
            e.an   = 4'hF;
            e.busy = 1'b0;
            e.ack  = 1'b0;
        end else begin
            pos      = n % RD;
            slot     = (n / RD) % N;
            boundary = (n % FRAME) == FRAME - 1;
            dark     = m_act_blank[slot];
            e.seg    = dark ? 7'h7F : seg_tab[m_act_bcd[slot*4 +: 4]];
            e.dp     = dark ? 1'b1 : ~m_act_dp[slot];
            e.an     = 4'hF;
            if (!dark && pos >= G) e.an[slot] = 1'b0;
            e.ack    = boundary && m_busy;
            if (e.ack) begin
                m_act_bcd   = m_pend_bcd;
                m_act_blank = m_pend_blank;
                m_act_dp    = m_pend_dp;
                m_busy      = 1'b0;
            end
            if (load) begin
                m_pend_bcd   = bcd_in;
                m_pend_blank = blank_in;
                m_pend_dp    = dp_in;
                m_busy       = 1'b1;
            end
            e.busy = m_busy;
            n++;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{seg: seg, dp: dp, an: an, busy: busy, ack: load_ack};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got seg=%h dp=%b an=%b busy=%b load_ack=%b, want seg=%h dp=%b an=%b busy=%b load_ack=%b",
                         $time, a.seg, a.dp, a.an, a.busy, a.ack, e.seg, e.dp, e.an, e.busy, e.ack);
            end
            vectors++;
            if ($countones(~an) > 1) begin
                miscompares++;
                $display("FAIL one_anode @%0t: got an=%b, want at most one low", $time, an);
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] bl, input logic [3:0] d);
        bcd_in   = b;
        blank_in = bl;
        dp_in    = d;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Wait until the next rising edge samples the given position within the frame.
    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME && (n % FRAME) != ph; i++) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0;
        blank_in = 4'h0;
        dp_in    = 4'h0;
        cyc(3);
        reset = 1'b0;
        cyc(2 * FRAME);

        do_load(16'h4321, 4'b0000, 4'b0010);
        cyc(3 * FRAME);

        do_load(16'hA0F5, 4'b0100, 4'b0000);
        cyc(3 * FRAME);

        wait_phase(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        cyc(1);
        do_load(16'h2222, 4'b0000, 4'b0000);
        cyc(3 * FRAME);

        wait_phase(2);
        do_load(16'h0005, 4'b0000, 4'b0001);
        wait_phase(FRAME - 1);
        do_load(16'h0009, 4'b0000, 4'b0000);
        cyc(3 * FRAME);

        wait_phase(6);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(FRAME);
        do_load(16'h8765, 4'b0000, 4'b1001);
        cyc(2 * FRAME);

        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 9) == 0);
            bcd_in   = 16'($urandom);
            blank_in = 4'($urandom);
            dp_in    = 4'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        load  = 1'b0;
        cyc(2);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed 4-digit seven-segment display driver for the elevator floor/status display.
- Sits directly downstream of the floor-code decode stage and consumes its BCD digits, one nibble per digit.
- Applies BCD-to-segment decoding, per-digit blanking and decimal point, anti-ghost guard time and tear-free double-buffered updates.
- Drives the board's common-anode display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles each digit is scanned (≥ GUARD+2)
GUARD, 2, cycles at the start of each digit slot with all anodes off

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
bcd_in  input  4*N_DIGITS  BCD digits; nibble i drives digit i (digit 0 rightmost)
blank_in  input  N_DIGITS  1 = digit i dark
dp_in  input  N_DIGITS  1 = decimal point of digit i lit
load  input  1  one-cycle strobe: capture bcd_in/blank_in/dp_in into pending buffer
busy  output  1  pending buffer holds data not yet shown
load_ack  output  1  one-cycle pulse when pending buffer is transferred to active buffer
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  N_DIGITS  digit anodes, active-low, at most one low at any time

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on reset, and takes priority over everything.
- Reset values:
  - seg=7'h7F, dp=1, an=all ones, busy=0, load_ack=0.
  - Prescaler=0, digit index=0.
  - Active buffer: digits 0, blank all ones, dp all zeros. Pending buffer cleared.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler==REFRESH_DIV-1).
  - On tick, index increments, wrapping N_DIGITS-1 -> 0.
  - A frame lasts N_DIGITS*REFRESH_DIV cycles.
- Outputs: all registered, derived from the index and prescaler values of the previous cycle.
  - Guard window: while prescaler < GUARD, an = all ones. seg and dp are still driven for the current index.
  - Otherwise, an[index]=0 unless blank[index]=1, in which case an = all ones.
  - When blank[index]=1, seg=7'h7F and dp=1 for the whole slot.
- Decode (active-low, a = bit 0):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10..15 display a dash: 7'h3F.
  - dp = ~dp_active[index].
- Double buffer:
  - load with busy=0: capture the inputs into pending and set busy=1.
  - load with busy=1: overwrite pending; the latest data wins.
  - Frame boundary = tick with index==N_DIGITS-1. At the boundary with busy=1:
    - active <= pending, busy <= 0.
    - load_ack=1 for exactly the next cycle.
  - The active buffer never changes mid-frame.
- Simultaneous load and frame-boundary transfer:
  - The previous pending contents transfer and load_ack pulses.
  - The new inputs are captured into pending and busy stays 1.
- load while reset=1 is ignored.
- Reset mid-frame: the display goes dark the next cycle and the pending data is lost.
- Display is dark (an all ones) at every slot boundary for GUARD cycles, so two anodes are never low in the same cycle.
- Decoder and scan logic are internal; no combinational path from any input to any output.

Test Plan:
- Bench parameters for all cases: N_DIGITS=4, REFRESH_DIV=4, GUARD=1.
- Reset: assert reset 3 cycles -> seg=7'h7F, an=4'hF, dp=1, busy=0, load_ack=0. After release, display stays dark, since the active buffer is all blank.
- Basic scan:
  - Stimulus: load bcd_in=16'h4321, blank_in=0, dp_in=4'b0010.
  - Required: busy=1 until the first frame boundary, then load_ack pulses once.
  - Next frame, in order: an=1110 with seg=7'h79, an=1101 with seg=7'h24 and dp=0, an=1011 with seg=7'h30, an=0111 with seg=7'h19.
  - Each digit lit 3 cycles, with 1 guard cycle an=4'hF between digits.
- Blanking and invalid code:
  - Stimulus: bcd_in=16'hA0F5, blank_in=4'b0100.
  - Required: digit0 seg=7'h12; digit1 seg=7'h3F; digit2 an=4'hF for the whole slot with seg=7'h7F; digit3 seg=7'h3F.
- Tear-free update:
  - Stimulus: load 16'h1111 mid-frame, then load 16'h2222 two cycles later, same frame.
  - Required: the current frame still shows the old data. At the boundary only 2222 is shown, with exactly one load_ack pulse.
- Load coincident with transfer:
  - Stimulus: load asserted on the boundary tick while pending holds 16'h0005.
  - Required: 0005 displayed, load_ack=1, busy remains 1, and the new value appears one frame later.
- Reset mid-frame: assert reset while an=1101 -> next cycle an=4'hF, busy=0, index restarts at 0.
